// File: rtl/dmem_io_bridge.sv
// CPU data-side bridge: decodes RAM / IO / unmapped regions and sequences reads.
// Optional macro BRIDGE_ERR_CNT_EN adds the saturating err_cnt output.
module dmem_io_bridge #(
   parameter logic [15:0] IO_BASE    = 16'hBFAF,
   parameter logic [15:0] RAM_BASE   = 16'h8004,
   parameter int          RAM_AW     = 14,
   parameter int          RAM_RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [31:0]       cpu_addr,
   input  logic [31:0]       cpu_wdata,
   output logic [31:0]       cpu_rdata,
   output logic              cpu_stall,
   output logic              ram_ce,
   output logic              ram_we,
   output logic [RAM_AW-1:0] ram_addr,
   output logic [31:0]       ram_wdata,
   input  logic [31:0]       ram_rdata,
   output logic              io_ce,
   output logic              io_we,
   output logic [31:0]       io_addr,
   output logic [31:0]       io_din,
`ifdef BRIDGE_ERR_CNT_EN
   output logic [15:0]       err_cnt,
`endif
   input  logic [31:0]       io_dout
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP
   } state_e;

   localparam logic [1:0] LAT_M1 = 2'(RAM_RD_LAT - 1);

   state_e      state_q;
   logic [1:0]  cnt_q;
   logic [31:0] rdata_q;

   logic hit_io;
   logic hit_ram;
   logic idle_req;
   logic rd_req;

   assign hit_io  = (cpu_addr[31:16] == IO_BASE);
   assign hit_ram = (cpu_addr[31:16] == RAM_BASE);

   // Gating with rst keeps stall/enables low while reset is held
   assign idle_req = (state_q == S_IDLE) && cpu_req && !rst;
   assign rd_req   = idle_req && !cpu_we;

   assign ram_ce    = (idle_req && hit_ram) || (state_q == S_WAIT);
   assign ram_we    = idle_req && hit_ram && cpu_we;
   assign ram_addr  = cpu_addr[RAM_AW+1:2];
   assign ram_wdata = cpu_wdata;

   assign io_ce   = idle_req && hit_io;
   assign io_we   = idle_req && hit_io && cpu_we;
   assign io_addr = cpu_addr;
   assign io_din  = cpu_wdata;

   assign cpu_stall = rd_req || (state_q == S_WAIT);
   assign cpu_rdata = rdata_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         rdata_q <= '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (rd_req) begin
                  if (hit_ram) begin
                     cnt_q   <= LAT_M1;
                     state_q <= S_WAIT;
                  end else if (hit_io) begin
                     rdata_q <= io_dout;
                     state_q <= S_RESP;
                  end else begin
                     rdata_q <= '0;
                     state_q <= S_RESP;
                  end
               end
            end
            S_WAIT: begin
               if (cnt_q == 2'd0) begin
                  rdata_q <= ram_rdata;
                  state_q <= S_RESP;
               end else begin
                  cnt_q <= cnt_q - 2'd1;
               end
            end
            S_RESP: state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

`ifdef BRIDGE_ERR_CNT_EN
   logic [15:0] err_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_q <= '0;
      end else if (idle_req && !hit_io && !hit_ram && err_q != 16'hFFFF) begin
         err_q <= err_q + 16'd1;
      end
   end

   assign err_cnt = err_q;
`endif

endmodule

// File: doc/dmem_io_bridge.md
Name: dmem_io_bridge

Overview:
- Sits between the CPU MEM stage and the data-side slaves: data RAM and the memory-mapped IO decoder (LED, RGB LED, 7-seg, timer).
- Decodes each CPU data access by address region and forwards it to the RAM port or the IO port.
- Sequences reads with a small FSM and stalls the pipeline until read data is returned registered.
- Unmapped accesses are absorbed: writes are dropped and reads return zero.

Parameters:
- IO_BASE, 16'hBFAF: addr[31:16] value that selects the IO region.
- RAM_BASE, 16'h8004: addr[31:16] value that selects the data RAM region.
- RAM_AW, 14: RAM word address width; ram_addr = cpu_addr[RAM_AW+1:2].
- RAM_RD_LAT, 1: RAM read latency in cycles, 1..3.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- cpu_req  in  1  data access valid; held stable by CPU while cpu_stall=1
- cpu_we  in  1  1=write, 0=read
- cpu_addr  in  32  byte address
- cpu_wdata  in  32  write data
- cpu_rdata  out  32  read data, valid in RESP cycle
- cpu_stall  out  1  pipeline stall request
- ram_ce  out  1  RAM enable
- ram_we  out  1  RAM write enable
- ram_addr  out  RAM_AW  RAM word address
- ram_wdata  out  32  RAM write data
- ram_rdata  in  32  RAM read data, RAM_RD_LAT cycles after ram_ce
- io_ce  out  1  IO decoder enable
- io_we  out  1  IO write enable
- io_addr  out  32  IO address, cpu_addr passed through
- io_din  out  32  IO write data, cpu_wdata passed through without byte swap (the decoder swaps)
- io_dout  in  32  IO read data, combinational
- err_cnt  out  16  unmapped-access count (only when the optional feature is compiled in)

Behaviour:
- Reset is asynchronous, active-high (rst). Reset values: state=IDLE, cpu_rdata=0, cpu_stall=0, all ce/we outputs 0, wait counter 0.
- Region decode is combinational on cpu_addr[31:16]:
  - hit_io = (cpu_addr[31:16] == IO_BASE)
  - hit_ram = (cpu_addr[31:16] == RAM_BASE)
  - neither = unmapped
- Slave-side ce/we are combinational from the decode and are active only in IDLE with cpu_req=1. In WAIT, ram_ce stays 1 with ram_we=0 and the address held.
- FSM states: IDLE, WAIT, RESP.
- IDLE, cpu_req=0: all enables 0, cpu_stall=0.
- IDLE, write request: ram_ce/ram_we or io_ce/io_we asserted for exactly that cycle. cpu_stall=0. Stay in IDLE. Zero-stall write.
- IDLE, RAM read: ram_ce=1, ram_we=0, cpu_stall=1. Load wait counter with RAM_RD_LAT-1 and go to WAIT.
- WAIT: cpu_stall=1.
  - When the counter is 0: capture ram_rdata into cpu_rdata and go to RESP.
  - Otherwise: decrement the counter.
- IDLE, IO read: io_ce=1, io_we=0, cpu_stall=1. Capture io_dout into cpu_rdata at the same edge and go to RESP.
- IDLE, unmapped read: cpu_stall=1. Load cpu_rdata=0 and go to RESP. No slave enable is driven.
- RESP: cpu_stall=0 and cpu_rdata holds its value. cpu_req is ignored because it is still the completed request. Next state is IDLE.
- Stall timing for reads:
  - RAM read: cpu_stall high for RAM_RD_LAT+1 cycles.
  - IO or unmapped read: cpu_stall high for 1 cycle.
- cpu_rdata holds its last value until the next read capture.
- Unmapped write: no enable driven, no stall, data dropped.
- Reset mid-operation (WAIT or RESP): returns to IDLE immediately, cpu_stall drops asynchronously, and any captured data is cleared to 0.
- A cpu_addr[1:0] misalignment is ignored; word access only.

Optional Feature:
- Macro: BRIDGE_ERR_CNT_EN.
- Defined:
  - err_cnt increments by 1 on every unmapped access (read or write) accepted in IDLE.
  - Saturates at 16'hFFFF.
  - Reset value 0.
- Undefined: the err_cnt port and its counter are absent. Unmapped behaviour is otherwise identical.

Test Plan:
- RAM write: addr=32'h8004_0010, wdata=32'hDEADBEEF, we=1 → same cycle ram_ce=1, ram_we=1, ram_addr=4, ram_wdata=32'hDEADBEEF; cpu_stall stays 0.
- RAM read, RAM_RD_LAT=1, model returns 32'h1234_5678 → cpu_stall=1 for 2 cycles; in the RESP cycle cpu_stall=0 and cpu_rdata=32'h1234_5678.
- IO read: addr=32'hBFAF_E000, io_dout=32'h0A00_0000 → io_ce=1 for 1 cycle, stall for 1 cycle, cpu_rdata=32'h0A00_0000 in RESP.
- IO write: addr=32'hBFAF_F000, wdata=32'h0000_00FF → io_we=1 and io_din=32'h0000_00FF for 1 cycle, no stall.
- Unmapped read then unmapped write: addr=32'h0000_0000 → read gives cpu_rdata=0 with a 1-cycle stall; no ram_ce/io_ce ever; with BRIDGE_ERR_CNT_EN, err_cnt=2.
- Assert rst in the WAIT cycle of a RAM read with RAM_RD_LAT=3 → cpu_stall=0 and cpu_rdata=0 immediately; after release, the next read completes normally.
